pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 22 ++
 rtl/pc_target_adder.sv | 26 ++
 rtl/pc_unit.sv | 105 ++++++++++
 tb/tb_pc_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// ============================================================================
//  Module      : pc_unit_pkg
//  Description : Shared widths, constants and state encoding for the PC unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

    localparam int                  PC_WIDTH             = 32;
    localparam logic [PC_WIDTH-1:0] PC_INCR              = 32'd4;
    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_target_adder.sv
// ============================================================================
//  Module      : pc_target_adder
//  Description : Computes PC+4 and the PC-relative redirect target.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_adder
    import pc_unit_pkg::*;
(
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [7:0]          i_offset,
    output logic [PC_WIDTH-1:0] o_pc_plus4,
    output logic [PC_WIDTH-1:0] o_target
);

    logic [PC_WIDTH-1:0] w_offset_bytes;

    // Word offset: sign-extend then scale by 4; all sums wrap mod 2^32.
    assign w_offset_bytes = {{(PC_WIDTH-10){i_offset[7]}}, i_offset, 2'b00};
    assign o_pc_plus4     = i_pc + PC_INCR;
    assign o_target       = o_pc_plus4 + w_offset_bytes;

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
//  Module      : pc_unit
//  Description : Program counter with boot delay, fetch stall and redirect hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int                  BOOT_CYCLES  = 1
)(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BUSYWAIT,
    input  logic                JUMP,
    input  logic                BRANCH,
    input  logic                ZERO,
    input  logic [7:0]          OFFSET,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PC_PLUS4,
    output logic                FETCH_VALID
);

    localparam logic [2:0] c_boot_last = 3'(BOOT_CYCLES - 1);

    pc_state_t           r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [2:0]          r_boot_cnt;
    logic                r_pending;
    logic [PC_WIDTH-1:0] r_pend_tgt;
    logic                r_fetch_valid;

    logic                w_taken;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_target;

    assign w_taken = JUMP | (BRANCH & ZERO);

    pc_target_adder u_adder (
        .i_pc       (r_pc),
        .i_offset   (OFFSET),
        .o_pc_plus4 (w_pc_plus4),
        .o_target   (w_target)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_boot_cnt    <= '0;
            r_pending     <= 1'b0;
            r_pend_tgt    <= '0;
            r_fetch_valid <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    if (r_boot_cnt == c_boot_last) begin
                        r_state       <= RUN;
                        r_fetch_valid <= 1'b1;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 3'd1;
                    end
                end
                RUN: begin
                    if (BUSYWAIT) begin
                        r_state <= HOLD;
                        if (w_taken) begin
                            r_pending  <= 1'b1;
                            r_pend_tgt <= w_target;
                        end
                    end else begin
                        r_pc <= w_taken ? w_target : w_pc_plus4;
                    end
                end
                HOLD: begin
                    // First redirect seen during a stall is the one honoured.
                    if (BUSYWAIT) begin
                        if (w_taken && !r_pending) begin
                            r_pending  <= 1'b1;
                            r_pend_tgt <= w_target;
                        end
                    end else begin
                        r_pc      <= r_pending ? r_pend_tgt
                                   : (w_taken ? w_target : w_pc_plus4);
                        r_pending <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                default: begin
                    r_state       <= BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign PC          = r_pc;
    assign PC_PLUS4    = w_pc_plus4;
    assign FETCH_VALID = r_fetch_valid;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Directed self-checking bench for pc_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT;
    logic        JUMP;
    logic        BRANCH;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        FETCH_VALID;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pc_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .BOOT_CYCLES  (1)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUSYWAIT    (BUSYWAIT),
        .JUMP        (JUMP),
        .BRANCH      (BRANCH),
        .ZERO        (ZERO),
        .OFFSET      (OFFSET),
        .PC          (PC),
        .PC_PLUS4    (PC_PLUS4),
        .FETCH_VALID (FETCH_VALID)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic bw, input logic j, input logic b,
                         input logic z, input logic [7:0] off);
        BUSYWAIT = bw;
        JUMP     = j;
        BRANCH   = b;
        ZERO     = z;
        OFFSET   = off;
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        chk("rst_pc",     PC,                 32'h0000_0000);
        chk("rst_pc4",    PC_PLUS4,           32'h0000_0004);
        chk("rst_fv",     {31'd0, FETCH_VALID}, 32'd0);

        // Release: one boot cycle with no fetch, then sequential fetch.
        RESET = 1'b0;
        chk("boot_fv",    {31'd0, FETCH_VALID}, 32'd0);
        tick();
        chk("run_fv",     {31'd0, FETCH_VALID}, 32'd1);
        chk("seq_pc0",    PC, 32'h0000_0000);
        tick();
        chk("seq_pc4",    PC, 32'h0000_0004);
        tick();
        chk("seq_pc8",    PC, 32'h0000_0008);
        tick();
        tick();
        chk("seq_pc10",   PC, 32'h0000_0010);

        // Conditional branch, taken and not taken.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hFE);
        tick();
        chk("br_taken",   PC, 32'h0000_000C);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("br_back10",  PC, 32'h0000_0010);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hFE);
        tick();
        chk("br_ntaken",  PC, 32'h0000_0014);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
        tick();
        chk("jmp_to20",   PC, 32'h0000_0020);

        // Three stall cycles; first redirect (0x34) wins over the second.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h04);
        tick();
        chk("stall1_pc",  PC, 32'h0000_0020);
        chk("stall_fv",   {31'd0, FETCH_VALID}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        tick();
        chk("stall2_pc",  PC, 32'h0000_0020);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("stall3_pc",  PC, 32'h0000_0020);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("pend_pc34",  PC, 32'h0000_0034);

        // JUMP and BRANCH together redirect to the same target.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h02);
        tick();
        chk("jb_both",    PC, 32'h0000_0040);

        // Stall with no redirect, then release together with a jump.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("hold40_pc",  PC, 32'h0000_0040);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
        tick();
        chk("rel_jmp",    PC, 32'h0000_004C);
        chk("rel_pc4",    PC_PLUS4, 32'h0000_0050);

        // Reset mid-stall with a pending target (0x90) that must be dropped.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        tick();
        chk("pend90_pc",  PC, 32'h0000_004C);
        RESET = 1'b1;
        tick();
        chk("mrst_pc",    PC, 32'h0000_0000);
        chk("mrst_pc4",   PC_PLUS4, 32'h0000_0004);
        chk("mrst_fv",    {31'd0, FETCH_VALID}, 32'd0);
        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("mrel_fv",    {31'd0, FETCH_VALID}, 32'd1);
        chk("mrel_pc",    PC, 32'h0000_0000);
        tick();
        chk("mrel_pc4",   PC, 32'h0000_0004);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("no_stale",   PC, 32'h0000_0008);

        // Wrap-around cases.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFD);
        tick();
        chk("jmp_to0",    PC, 32'h0000_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFE);
        tick();
        chk("jmp_top",    PC, 32'hFFFF_FFFC);
        chk("top_pc4",    PC_PLUS4, 32'h0000_0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("wrap_pc0",   PC, 32'h0000_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
        tick();
        chk("neg_max",    PC, 32'hFFFF_FE04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
